uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the baud tick generator. It consumes the one-clock `baud_tick` pulse, one per bit period.
- Serialises bytes from a valid/ready source into standard async frames on `tx`: start bit, LSB-first data, optional parity, stop bits.
- A one-entry pending register gives back-to-back frames with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock, same domain as the baud generator.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk pulse per bit period, from the baud generator.
- tx_data  input  DATA_BITS  byte to send.
- tx_valid  input  1  source has data.
- tx_ready  output  1  block can accept; transfer occurs when tx_valid && tx_ready at a clk edge.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress or pending.
- tx_done  output  1  one-clk pulse when the final stop bit completes.

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-high.
  - Reset values: tx=1, tx_ready=0 while rst=1 and 1 from the first cycle after release.
  - Also reset: busy=0, tx_done=0, pending=0, state=IDLE.
- States: IDLE, START, DATA, PARITY (only if compiled), STOP.
- State changes happen only on clk edges where baud_tick=1, except handshake acceptance.
- Each clk cycle with baud_tick=1 counts as one tick. There is no edge detection; upstream guarantees single-cycle pulses.
- tx_ready = !pending && (state==IDLE || (state==STOP && on last stop bit)).
- Accept: latch tx_data into the pending register and set pending=1. tx_ready drops the next cycle. tx_data is don't-care after acceptance.
- IDLE:
  - tx=1.
  - On a tick with pending=1: load the shift register from pending, clear pending, go to START, tx<=0.
  - Start-bit latency after acceptance is 1 tick; worst case one bit period.
  - Acceptance and a tick in the same cycle: the data is accepted, and the frame starts on the following tick.
- START: tx=0 for one tick period. On a tick: go to DATA, tx<=bit0, bit counter=0.
- DATA:
  - On each tick: counter increments and tx<=next bit (LSB first).
  - After the DATA_BITS-th bit period: go to PARITY if compiled, else STOP with tx<=1.
  - Counter width is ceil(log2(DATA_BITS)); no wrap is possible.
- PARITY: tx = XOR of the data bits, inverted if PARITY_ODD=1. Held one tick period, then go to STOP with tx<=1.
- STOP:
  - tx=1 for STOP_BITS tick periods.
  - On the tick ending the last stop bit: tx_done=1 for that one cycle.
  - If pending=1 (including a same-cycle acceptance), go directly to START with tx<=0, giving zero idle bits.
  - Otherwise go to IDLE.
- busy = (state!=IDLE) || pending.
- Reset mid-frame: tx=1 on the next cycle, the frame is abandoned, pending is cleared, no tx_done.
- Frame length: 1 + DATA_BITS + [1] + STOP_BITS tick periods.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present and one parity bit is inserted after the data, per PARITY_ODD.
- Undefined: no PARITY state or parity logic; DATA goes straight to STOP; PARITY_ODD is ignored.

Test Plan:
- Reset: hold rst=1 for 3 clks with tx_valid=1 and tx_data=0x3C. Required: tx=1, tx_ready=0, busy=0 during reset. First cycle after release: tx_ready=1, nothing accepted until then.
- Single frame: 8N1, baud_tick every 16 clks, send 0xA5.
  - tx per tick period: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - tx_done pulses exactly once, at the tick ending the stop bit.
  - busy is 0 afterwards.
- Back-to-back: hold tx_valid with 0x00, then 0xFF.
  - Second accepted during the first frame's stop bit.
  - Second start bit begins on the tick immediately after the first stop, with no idle bit period.
  - tx_done pulses twice, 10 tick periods apart.
- Backpressure: change tx_data while tx_valid=1 mid-frame. Required: tx_ready=0 from the cycle after acceptance until the last stop bit; the transmitted byte equals the originally accepted value.
- Reset mid-frame: assert rst for 1 clk after 4 data bits of 0x0F. Required: tx=1 the next cycle, no tx_done, and the next accepted byte transmits a correct full frame.
- Parity with UART_TX_PARITY_EN, STOP_BITS=2:
  - 0x07 with PARITY_ODD=0 gives parity bit 1; with PARITY_ODD=1 gives 0.
  - Stop level lasts 2 tick periods; frame length is 12 ticks.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit stage fed by a baud tick generator. Serialises words from a
//   valid/ready source into async frames on tx:
//     start bit (0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits (1).
//   A one-entry pending register holds the next word, so frames can run back
//   to back with no idle bit between them.
//
//   Optional feature: define UART_TX_PARITY_EN to insert one parity bit after
//   the data (even when PARITY_ODD=0, odd when PARITY_ODD=1). When the macro is
//   undefined there is no parity state and PARITY_ODD has no effect.
//
// Ports
//   clk        system clock (same domain as the baud generator)
//   rst        synchronous, active-high reset
//   baud_tick  one-clk pulse per bit period
//   tx_data    word to send, sampled on acceptance only
//   tx_valid   source has data
//   tx_ready   block can accept (transfer on tx_valid && tx_ready)
//   tx         serial line, idle high, registered
//   busy       frame in progress or word pending
//   tx_done    one-clk pulse when the final stop bit completes
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(DATA_BITS);

  // Reject configurations the frame logic is not built for.
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_serializer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 pending;
  logic [DATA_BITS-1:0] pend_data;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] load_src;
  logic [CW-1:0]        bit_cnt, cnt_nxt;
  logic                 stop_cnt, stop_nxt;
  logic                 last_stop;
  logic                 accept;
  logic                 load, load_direct, shift_en;
  logic                 tx_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign last_stop = (state == S_STOP) && (stop_cnt == 1'(STOP_BITS - 1));
  assign tx_ready  = !rst && !pending && ((state == S_IDLE) || last_stop);
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != S_IDLE) || pending;
  // A word accepted on the very tick that ends the last stop bit bypasses
  // the pending register and goes straight into the shifter.
  assign load_src  = load_direct ? tx_data : pend_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx;
    load        = 1'b0;
    load_direct = 1'b0;
    shift_en    = 1'b0;
    done_nxt    = 1'b0;
    cnt_nxt     = bit_cnt;
    stop_nxt    = stop_cnt;
    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (pending) begin
            state_nxt = S_START;
            tx_nxt    = 1'b0;
            load      = 1'b1;
          end
        end
        S_START: begin
          state_nxt = S_DATA;
          tx_nxt    = shreg[0];
          cnt_nxt   = '0;
        end
        S_DATA: begin
          if (bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
            tx_nxt    = par_bit;
`else
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
            stop_nxt  = 1'b0;
`endif
          end else begin
            // shreg[0] is on the line; shreg[1] is the next bit out
            cnt_nxt  = bit_cnt + CW'(1);
            tx_nxt   = shreg[1];
            shift_en = 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          stop_nxt  = 1'b0;
        end
`endif
        S_STOP: begin
          if (last_stop) begin
            done_nxt = 1'b1;
            if (pending || accept) begin
              state_nxt   = S_START;
              tx_nxt      = 1'b0;
              load        = 1'b1;
              load_direct = !pending;
            end else begin
              state_nxt = S_IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      pending  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
      bit_cnt  <= cnt_nxt;
      stop_cnt <= stop_nxt;
      if (accept && !load_direct) pending <= 1'b1;
      else if (load)              pending <= 1'b0;
    end
  end

  // Data path needs no reset: contents are only used after a load.
  always_ff @(posedge clk) begin
    if (accept && !load_direct) pend_data <= tx_data;
    if (load)          shreg <= load_src;
    else if (shift_en) shreg <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
    if (load) par_bit <= (^load_src) ^ 1'(PARITY_ODD);
`endif
  end

endmodule
